rvee_alu_dec: RTL

- Decode/operand stage directly upstream of the RVee ALU.
- Takes an RV32I instruction word, PC and register-file read data, and produces the ALU control bundle `op`, `a`, `b`, `c`, `msb_xor` and `sra`, plus writeback tags.
- Pre-conditions the operands for the shared adder:
  - `b` is inverted and `c`=1 for SUB/SLT/SLTU.
  - `msb_xor` is set for the signed-compare sign-differ case.
- Output is registered behind a 2-entry skid buffer with valid/ready handshakes on both sides.

---
 rtl/rvee_alu_pkg.sv | 17 +
 rtl/rvee_dec_pkg.sv | 27 ++
 rtl/rvee_alu_dec_if.sv | 35 +++
 rtl/rvee_skid_buf.sv | 94 +++++++++
 rtl/rvee_alu_dec.sv | 137 +++++++++++++
 5 files changed

// File: rtl/rvee_alu_pkg.sv
// Shared RVee ALU definitions: datapath width and the funct3-encoded ALU op set.
package rvee_alu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SLL  = 3'd1,
    ALU_SLT  = 3'd2,
    ALU_SLTU = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SRL  = 3'd5,
    ALU_OR   = 3'd6,
    ALU_AND  = 3'd7
  } alu_op_e;

endpackage

// File: rtl/rvee_dec_pkg.sv
// Decode-stage definitions: RV32I opcode/funct7 constants and the decoded ALU bundle.
package rvee_dec_pkg;
  import rvee_alu_pkg::*;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_e          op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic             c;
    logic             msb_xor;
    logic             sra;
    logic [4:0]       rd;
    logic             we;
    logic             illegal;
  } dec_t;

  localparam int unsigned DEC_W = $bits(dec_t);

endpackage

// File: rtl/rvee_alu_dec_if.sv
// Handshake/bus bundle between the register-read stage, the decoder and the ALU/EX stage.
interface rvee_alu_dec_if #(
  parameter int unsigned XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_insn;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      out_op;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic            out_c;
  logic            out_msb_xor;
  logic            out_sra;
  logic [4:0]      out_rd;
  logic            out_we;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_insn, in_pc, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, out_op, out_a, out_b, out_c, out_msb_xor,
           out_sra, out_rd, out_we, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_insn, in_pc, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, out_op, out_a, out_b, out_c, out_msb_xor,
           out_sra, out_rd, out_we, out_illegal
  );
endinterface

// File: rtl/rvee_skid_buf.sv
// Two-entry registered skid buffer; in_ready and out_valid both come straight from flops.
module rvee_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         in_fire, out_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Head slot always drives the output; the skid slot only fills while the head is stalled.
  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    skid_d   = skid_q;
    in_fire  = in_valid & in_ready_q;
    out_fire = out_valid_q & out_ready;

    case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          state_d = S_ONE;
          head_d  = in_data;
        end
      end
      S_ONE: begin
        if (in_fire && out_fire) begin
          head_d = in_data;
        end else if (out_fire) begin
          state_d = S_EMPTY;
        end else if (in_fire) begin
          state_d = S_TWO;
          skid_d  = in_data;
        end
      end
      S_TWO: begin
        if (out_fire) begin
          state_d = S_ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    // Redirect discards everything, including a same-cycle input.
    if (flush) begin
      state_d = S_EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end

    in_ready_d  = (state_d != S_TWO);
    out_valid_d = (state_d != S_EMPTY);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_q;

endmodule

// File: rtl/rvee_alu_dec.sv
// RV32I decode/operand stage feeding the RVee ALU through a 2-entry skid buffer.
// Define RVEE_ALU_DEC_UPPER_EN to decode LUI/AUIPC as ADD; otherwise they are illegal.
module rvee_alu_dec
  import rvee_alu_pkg::*;
  import rvee_dec_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic            clk,
  input logic            rst,
  rvee_alu_dec_if.slave  bus
);

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] u_imm;
  logic [XLEN-1:0] a_v;
  logic [XLEN-1:0] b_orig;
  logic            legal;
  logic            is_sub;
  logic            is_sra;
  logic            is_cmp;
  logic            is_upper;
  logic            inv_b;
  dec_t            dec;
  dec_t            out_q;
  logic            unused_bits;

  assign opcode = bus.in_insn[6:0];
  assign rd     = bus.in_insn[11:7];
  assign f3     = bus.in_insn[14:12];
  assign f7     = bus.in_insn[31:25];
  assign i_imm  = XLEN'($signed(bus.in_insn[31:20]));
  assign u_imm  = XLEN'({bus.in_insn[31:12], 12'b0});

  // Register indices are consumed by the register file upstream, not here.
`ifdef RVEE_ALU_DEC_UPPER_EN
  assign unused_bits = ^bus.in_insn[19:15];
`else
  assign unused_bits = ^{bus.in_insn[19:15], bus.in_pc};
`endif

  // Classify the instruction and select raw operands.
  always_comb begin
    a_v      = '0;
    b_orig   = '0;
    legal    = 1'b0;
    is_sub   = 1'b0;
    is_sra   = 1'b0;
    is_upper = 1'b0;

    case (opcode)
      OPC_OP: begin
        a_v    = bus.in_rs1;
        b_orig = bus.in_rs2;
        legal  = (f7 == F7_BASE) ||
                 ((f7 == F7_ALT) && ((f3 == ALU_ADD) || (f3 == ALU_SRL)));
        is_sub = (f7 == F7_ALT) && (f3 == ALU_ADD);
        is_sra = (f7 == F7_ALT) && (f3 == ALU_SRL);
      end
      OPC_OP_IMM: begin
        a_v    = bus.in_rs1;
        b_orig = i_imm;
        case (f3)
          ALU_SLL: legal = (f7 == F7_BASE);
          ALU_SRL: begin
            legal  = (f7 == F7_BASE) || (f7 == F7_ALT);
            is_sra = (f7 == F7_ALT);
          end
          default: legal = 1'b1;
        endcase
      end
`ifdef RVEE_ALU_DEC_UPPER_EN
      OPC_LUI: begin
        b_orig   = u_imm;
        legal    = 1'b1;
        is_upper = 1'b1;
      end
      OPC_AUIPC: begin
        a_v      = bus.in_pc;
        b_orig   = u_imm;
        legal    = 1'b1;
        is_upper = 1'b1;
      end
`endif
      default: legal = 1'b0;
    endcase
  end

  // Pre-condition operands for the shared adder: subtract and compares use a + ~b + 1.
  always_comb begin
    is_cmp = !is_upper && ((f3 == ALU_SLT) || (f3 == ALU_SLTU));
    inv_b  = is_sub || is_cmp;

    dec         = '0;
    dec.op      = ALU_ADD;
    dec.rd      = rd;
    dec.illegal = !legal;
    if (legal) begin
      dec.op      = is_upper ? ALU_ADD : alu_op_e'(f3);
      dec.a       = a_v;
      dec.b       = inv_b ? ~b_orig : b_orig;
      dec.c       = inv_b;
      dec.msb_xor = is_cmp && (a_v[XLEN-1] ^ b_orig[XLEN-1]);
      dec.sra     = is_sra;
      dec.we      = (rd != 5'd0);
    end
  end

  rvee_skid_buf #(
    .W (DEC_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (dec),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_q)
  );

  assign bus.out_op      = out_q.op;
  assign bus.out_a       = out_q.a;
  assign bus.out_b       = out_q.b;
  assign bus.out_c       = out_q.c;
  assign bus.out_msb_xor = out_q.msb_xor;
  assign bus.out_sra     = out_q.sra;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_we      = out_q.we;
  assign bus.out_illegal = out_q.illegal;

endmodule
